// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage. It drives a word address to a
//             combinational-read instruction memory and registers the
//             returned word into a one-entry output slot for decode.
//             The stage supports backpressure, halt and branch/jump
//             redirect, and it counts the instructions that decode accepts.
//  Ports    : clk          - rising-edge clock
//             rst_n        - asynchronous active-low reset
//             mem_addr     - word address to memory (combinational)
//             mem_data     - memory read data for mem_addr, same cycle
//             redirect     - restart fetch at redirect_pc
//             redirect_pc  - redirect target word address
//             halt         - suppress new captures while high
//             instr        - registered instruction word
//             instr_pc     - registered word address of instr
//             instr_valid  - instr/instr_pc hold a valid instruction
//             instr_ready  - decode accepts instr this cycle
//             fetch_count  - count of accepted instructions (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter logic [9:0] RESET_PC = 10'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [9:0]  mem_addr,
   input  logic [31:0] mem_data,
   input  logic        redirect,
   input  logic [9:0]  redirect_pc,
   input  logic        halt,
   output logic [31:0] instr,
   output logic [9:0]  instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] fetch_count
);

   logic [9:0]  r_pc;
   logic [31:0] r_instr;
   logic [9:0]  r_instr_pc;
   logic        r_instr_valid;
   logic [15:0] r_fetch_count;

   logic        w_slot_free;
   logic        w_accept;
   logic        w_capture;

   // A redirect target bypasses the pc so the target is fetched in the
   // same cycle as the request. This gives a one-cycle redirect-to-valid path.
   assign mem_addr    = redirect ? redirect_pc : r_pc;

   assign w_slot_free = !r_instr_valid || instr_ready;
   assign w_accept    = r_instr_valid && instr_ready;
   // A redirect overrides a stalled slot. The unaccepted word is dropped.
   assign w_capture   = !halt && (w_slot_free || redirect);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_instr_pc    <= 10'd0;
         r_instr_valid <= 1'b0;
         r_fetch_count <= 16'd0;
      end else begin
         // The count depends only on the handshake. A word that is accepted
         // on a redirect cycle still counts before the slot is replaced.
         if (w_accept) begin
            r_fetch_count <= r_fetch_count + 16'd1;
         end

         if (w_capture) begin
            r_instr       <= mem_data;
            r_instr_pc    <= mem_addr;
            r_instr_valid <= 1'b1;
            r_pc          <= mem_addr + 10'd1;   // wraps modulo 1024
         end else if (halt && redirect) begin
            // Record the target only. Fetch resumes there when the halt is released.
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
         end else if (halt && w_slot_free) begin
            r_instr_valid <= 1'b0;
         end
         // The remaining case is a stalled slot without redirect. Everything holds.
      end
   end

   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed self-checking bench for instr_fetch. The memory model
//             returns mem[i] = i. The expected values are computed by hand
//             for each step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data;
   logic        redirect;
   logic [9:0]  redirect_pc;
   logic        halt;
   logic [31:0] instr;
   logic [9:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] fetch_count;

   int total;
   int bad;

   instr_fetch #(.RESET_PC(10'd0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .fetch_count (fetch_count)
   );

   // Preloaded memory: mem[i] = i, combinational read
   assign mem_data = {22'd0, mem_addr};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the whole output slot and the count together.
   task automatic check_slot(input string tag, input logic v, input logic [9:0] pc,
                             input logic [15:0] cnt);
      check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
      if (v) begin
         check({tag, ".pc"},    {22'd0, instr_pc}, {22'd0, pc});
         check({tag, ".instr"}, instr, {22'd0, pc});
      end
      check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 10'd0;
      halt        = 1'b0;
      instr_ready = 1'b1;

      // Reset state
      #3;
      check("rst.valid", {31'd0, instr_valid}, 32'd0);
      check("rst.instr", instr, 32'd0);
      check("rst.pc",    {22'd0, instr_pc}, 32'd0);
      check("rst.count", {16'd0, fetch_count}, 32'd0);
      check("rst.addr",  {22'd0, mem_addr}, 32'd0);

      // Streaming with ready=1
      #9 rst_n = 1'b1;                          // t=12, between edges
      step();
      check_slot("stream0", 1'b1, 10'd0, 16'd0);
      check("stream0.addr", {22'd0, mem_addr}, 32'd1);
      for (int k = 1; k <= 5; k++) begin
         step();
         check_slot("stream", 1'b1, 10'(k), 16'(k));
      end

      // Backpressure for 3 cycles while holding pc 5
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_slot("bp", 1'b1, 10'd5, 16'd5);
         check("bp.addr", {22'd0, mem_addr}, 32'd6);
      end
      instr_ready = 1'b1;
      step();
      check_slot("bp_rel6", 1'b1, 10'd6, 16'd6);
      step();
      check_slot("bp_rel7", 1'b1, 10'd7, 16'd7);

      // Redirect while stalled on pc 7, so instruction 7 is discarded
      instr_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 10'd200;
      #1;
      check("redir.addr", {22'd0, mem_addr}, 32'd200);
      step();
      check_slot("redir200", 1'b1, 10'd200, 16'd7);
      redirect    = 1'b0;
      instr_ready = 1'b1;
      step();
      check_slot("redir201", 1'b1, 10'd201, 16'd8);

      // Redirect with ready=1 counts the old word, then wraps the address
      redirect    = 1'b1;
      redirect_pc = 10'd1022;
      step();
      check_slot("wrap1022", 1'b1, 10'd1022, 16'd9);
      redirect = 1'b0;
      step();
      check_slot("wrap1023", 1'b1, 10'd1023, 16'd10);
      step();
      check_slot("wrap0", 1'b1, 10'd0, 16'd11);
      step();
      check_slot("wrap1", 1'b1, 10'd1, 16'd12);
      step();
      check_slot("pre2", 1'b1, 10'd2, 16'd13);
      step();
      check_slot("pre3", 1'b1, 10'd3, 16'd14);

      // Halt for 2 cycles after pc 3
      halt = 1'b1;
      step();
      check_slot("halt_a", 1'b0, 10'd0, 16'd15);
      check("halt_a.addr", {22'd0, mem_addr}, 32'd4);
      step();
      check_slot("halt_b", 1'b0, 10'd0, 16'd15);
      halt = 1'b0;
      step();
      check_slot("unhalt4", 1'b1, 10'd4, 16'd15);

      // Redirect during halt: the target is recorded and no word is captured
      halt        = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 10'd300;
      step();
      check_slot("hredir", 1'b0, 10'd0, 16'd16);
      redirect = 1'b0;
      #1;
      check("hredir.addr", {22'd0, mem_addr}, 32'd300);
      halt = 1'b0;
      step();
      check_slot("hredir300", 1'b1, 10'd300, 16'd16);

      // Stall, then an asynchronous reset pulse between edges
      instr_ready = 1'b0;
      step();
      check_slot("stall300", 1'b1, 10'd300, 16'd16);
      #3 rst_n = 1'b0;
      #1;
      check("arst.valid", {31'd0, instr_valid}, 32'd0);
      check("arst.instr", instr, 32'd0);
      check("arst.pc",    {22'd0, instr_pc}, 32'd0);
      check("arst.count", {16'd0, fetch_count}, 32'd0);
      check("arst.addr",  {22'd0, mem_addr}, 32'd0);
      #1 rst_n = 1'b1;
      instr_ready = 1'b1;
      step();
      check_slot("restart0", 1'b1, 10'd0, 16'd0);
      step();
      check_slot("restart1", 1'b1, 10'd1, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 10'd0, word address fetched first after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_addr  output  10  word address driven to the memory block's Addr port.
REQ-005 mem_data  input  32  memory DataOut, valid combinationally in the same cycle as mem_addr.
REQ-006 redirect  input  1  branch/jump request: restart fetch at redirect_pc.
REQ-007 redirect_pc  input  10  target word address, sampled only when redirect=1.
REQ-008 halt  input  1  level: when 1, no new fetch is captured.
REQ-009 instr  output  32  registered instruction word to decode.
REQ-010 instr_pc  output  10  registered word address of instr.
REQ-011 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-012 instr_ready  input  1  decode accepts instr this cycle.
REQ-013 fetch_count  output  16  number of instructions accepted by decode (instr_valid & instr_ready).

Function
REQ-014 Internal register pc (10 bits) SHALL hold the next address to fetch.
REQ-015 mem_addr SHALL equal redirect_pc when redirect=1, else pc (combinational).
REQ-016 The output slot is "free" in a cycle when instr_valid=0 or instr_ready=1.
REQ-017 Capture: on a clock edge with halt=0 and (slot free or redirect=1), instr<=mem_data, instr_pc<=mem_addr, instr_valid<=1, pc<=mem_addr+1.
REQ-018 Hold: on an edge with redirect=0 and instr_valid=1 and instr_ready=0, pc, instr, instr_pc and instr_valid SHALL remain unchanged.
REQ-019 Drain: on an edge with halt=1, redirect=0 and slot free, instr_valid<=0 and pc unchanged.
REQ-020 Redirect has priority over hold; an unaccepted instr SHALL be discarded (not counted) when redirect=1 and instr_ready=0.
REQ-021 Redirect with halt=1: pc<=redirect_pc, instr_valid<=0, no capture.
REQ-022 Redirect with instr_ready=1 in the same cycle: the old instr SHALL be counted as accepted, then replaced per REQ-017.
REQ-023 Latency: instruction at address A is presented with instr_valid=1 the cycle after the edge at which mem_addr=A was captured; redirect-to-valid is 1 cycle.
REQ-024 pc arithmetic is modulo 1024: 10'd1023+1 SHALL wrap to 10'd0 with no stall or flag.
REQ-025 fetch_count SHALL increment by 1 on every edge with instr_valid=1 and instr_ready=1, wrapping 16'hFFFF->0.
REQ-026 instr and instr_pc SHALL NOT change while instr_valid=1 and instr_ready=0 and redirect=0.
REQ-027 The block SHALL never write memory; no write-enable is driven.

Reset
REQ-028 While rst_n=0, asynchronously: pc=RESET_PC, instr=32'd0, instr_pc=10'd0, instr_valid=0, fetch_count=16'd0.
REQ-029 mem_addr during reset SHALL equal RESET_PC (absent redirect).
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first edge after rst_n rises with halt=0 captures address RESET_PC.

Verification
REQ-031 Reset release, memory preloaded mem[i]=i, instr_ready=1, halt=0 -> instr_valid=1 from cycle 1, instr/instr_pc = 0,1,2,3,... one per cycle; fetch_count increments each cycle.
REQ-032 Backpressure: instr_ready=0 for 3 cycles while instr_pc=5 -> instr=5, instr_pc=5, mem_addr=6 held all 3 cycles; after ready=1, sequence continues 6,7 with no gaps or duplicates.
REQ-033 Redirect to 10'd200 while instr_ready=0 holding instr_pc=7 -> next cycle instr_pc=200, instr_valid=1, fetch_count unchanged by instr 7.
REQ-034 Wrap: redirect_pc=10'd1022, ready=1 -> instr_pc sequence 1022, 1023, 0, 1.
REQ-035 halt=1 for 2 cycles with ready=1 after instr_pc=3 -> instr_valid=0 for 2 cycles; on halt=0 next instr_pc=4.
REQ-036 rst_n pulsed low asynchronously between edges during a stall -> outputs go to reset values immediately; fetch restarts at RESET_PC.
